hv_reg_acc_ctrl: RTL and testbench

- Register-access controller directly downstream of the SPI/OWT access arbiter.
- Accepts one level-held write or read request at a time.
- Checks the CRC on writes and range-checks every address.
- Drives a single-port register file. Returns a one-cycle write or read acknowledge with read data and echoed address.
- Reports CRC and address errors to the fault/status logic.

---
 rtl/hv_reg_acc_ctrl_pkg.sv | 32 +++
 rtl/hv_reg_acc_ctrl_if.sv | 42 ++++
 rtl/hv_reg_acc_ctrl_crc.sv | 31 +++
 rtl/hv_reg_acc_ctrl.sv | 210 +++++++++++++++++++++
 tb/tb_hv_reg_acc_ctrl.sv | 294 +++++++++++++++++++++++++++++
 5 files changed

// File: rtl/hv_reg_acc_ctrl_pkg.sv
// -----------------------------------------------------------------------------
// hv_rac_pkg
// Shared definitions for the register-access controller (hv_reg_acc_ctrl):
//   - rac_state_e : controller FSM states
//   - rac_op_e    : latched access type (write / read)
//   - CRC8_POLY / CRC8_INIT : CRC-8 parameters protecting write requests
//   - default widths and register count of the register file
// -----------------------------------------------------------------------------
package hv_rac_pkg;

  localparam int REG_AW_DEF    = 7;
  localparam int REG_DW_DEF    = 8;
  localparam int REG_CRC_W_DEF = 8;
  localparam int REG_NUM_DEF   = 96;

  localparam logic [7:0] CRC8_POLY = 8'h07;
  localparam logic [7:0] CRC8_INIT = 8'h00;

  typedef enum logic [2:0] {
    ST_IDLE = 3'd0,
    ST_CHK  = 3'd1,
    ST_EXE  = 3'd2,
    ST_RDW  = 3'd3,
    ST_ACK  = 3'd4
  } rac_state_e;

  typedef enum logic {
    OP_WR = 1'b0,
    OP_RD = 1'b1
  } rac_op_e;

endpackage

// File: rtl/hv_reg_acc_ctrl_if.sv
// -----------------------------------------------------------------------------
// hv_rac_if
// Request/acknowledge bus between the SPI/OWT access arbiter (master) and the
// register-access controller (slave).
//   i_rac_wr_req  : write request, level, held until o_rac_wack
//   i_rac_rd_req  : read request, level, held until o_rac_rack
//   i_rac_addr    : access address
//   i_rac_wdata   : write data
//   i_rac_wcrc    : CRC-8 over {1'b0, addr, wdata}
//   o_rac_wack    : write acknowledge pulse
//   o_rac_rack    : read acknowledge pulse
//   o_rac_data    : read data, valid with o_rac_rack
//   o_rac_addr    : address of the acknowledged access
// Signal names keep the controller-side i_/o_ prefixes.
// -----------------------------------------------------------------------------
interface hv_rac_if #(
  parameter int REG_AW    = 7,
  parameter int REG_DW    = 8,
  parameter int REG_CRC_W = 8
);

  logic                 i_rac_wr_req;
  logic                 i_rac_rd_req;
  logic [REG_AW-1:0]    i_rac_addr;
  logic [REG_DW-1:0]    i_rac_wdata;
  logic [REG_CRC_W-1:0] i_rac_wcrc;
  logic                 o_rac_wack;
  logic                 o_rac_rack;
  logic [REG_DW-1:0]    o_rac_data;
  logic [REG_AW-1:0]    o_rac_addr;

  modport master (
    output i_rac_wr_req, i_rac_rd_req, i_rac_addr, i_rac_wdata, i_rac_wcrc,
    input  o_rac_wack, o_rac_rack, o_rac_data, o_rac_addr
  );

  modport slave (
    input  i_rac_wr_req, i_rac_rd_req, i_rac_addr, i_rac_wdata, i_rac_wcrc,
    output o_rac_wack, o_rac_rack, o_rac_data, o_rac_addr
  );

endinterface

// File: rtl/hv_reg_acc_ctrl_crc.sv
// -----------------------------------------------------------------------------
// crc16to8_parallel
// Combinational CRC-8 (poly CRC8_POLY, init CRC8_INIT, MSB first, no reflection,
// no final XOR) over a 16-bit word, fully unrolled into one cycle.
//   i_data : 16-bit message, bit 15 processed first
//   o_crc  : resulting CRC-8
// -----------------------------------------------------------------------------
module crc16to8_parallel
  import hv_rac_pkg::*;
(
  input  logic [15:0] i_data,
  output logic [7:0]  o_crc
);

  logic [7:0] w_crc;
  logic       w_fb;

  // NOTE: always_comb uses blocking '=' so each unrolled step sees the previous
  // step's value; every variable gets a default first so no latch is inferred.
  always_comb begin
    w_crc = CRC8_INIT;
    w_fb  = 1'b0;
    for (int i = 15; i >= 0; i--) begin
      w_fb  = w_crc[7] ^ i_data[i];
      w_crc = {w_crc[6:0], 1'b0} ^ (w_fb ? CRC8_POLY : 8'h00);
    end
  end

  assign o_crc = w_crc;

endmodule

// File: rtl/hv_reg_acc_ctrl.sv
// -----------------------------------------------------------------------------
// hv_reg_acc_ctrl
// Register-access controller downstream of the SPI/OWT access arbiter. Accepts
// one level-held request at a time, checks the write CRC and the address range,
// drives a single-port register file and returns a one-cycle acknowledge.
//
// Ports:
//   i_clk, i_rst_n  : clock, synchronous active-low reset
//   rac             : hv_rac_if.slave request/acknowledge bus
//   o_reg_wr_en     : register-file write strobe
//   o_reg_rd_en     : register-file read strobe
//   o_reg_addr      : register-file address
//   o_reg_wdata     : register-file write data
//   i_reg_rdata     : register-file read data, valid 1 cycle after o_reg_rd_en
//   o_crc_err       : pulse, write dropped on CRC mismatch
//   o_addr_err      : pulse, access to address >= REG_NUM
//   i_err_cnt_clr   : clear the CRC error counter
//   o_crc_err_cnt   : saturating CRC error count
//
// Build option: define HV_RAC_ERR_CNT_EN to enable the CRC error counter;
// otherwise o_crc_err_cnt is 0 and i_err_cnt_clr is ignored.
//
// Timing (cycle 0 = request seen in IDLE):
//   write: CHK at 1, strobe/error pulses at 2 (EXE), wack at 3 (ACK)
//   read : rd_en at 2 (EXE), data returned at 3 (RDW), rack at 4 (ACK)
//   errored read skips RDW: addr_err at 2, rack with data 0 at 3
// -----------------------------------------------------------------------------
module hv_reg_acc_ctrl
  import hv_rac_pkg::*;
#(
  parameter int REG_AW    = REG_AW_DEF,
  parameter int REG_DW    = REG_DW_DEF,
  parameter int REG_CRC_W = REG_CRC_W_DEF,
  parameter int REG_NUM   = REG_NUM_DEF
) (
  input  logic              i_clk,
  input  logic              i_rst_n,
  hv_rac_if.slave           rac,
  output logic              o_reg_wr_en,
  output logic              o_reg_rd_en,
  output logic [REG_AW-1:0] o_reg_addr,
  output logic [REG_DW-1:0] o_reg_wdata,
  input  logic [REG_DW-1:0] i_reg_rdata,
  output logic              o_crc_err,
  output logic              o_addr_err,
  input  logic              i_err_cnt_clr,
  output logic [7:0]        o_crc_err_cnt
);

  // One extra bit so REG_NUM == 2**REG_AW is still representable.
  localparam logic [REG_AW:0] REG_NUM_W = (REG_AW+1)'(REG_NUM);

  rac_state_e           r_state;
  rac_op_e              r_op;
  logic [REG_AW-1:0]    r_addr;
  logic [REG_DW-1:0]    r_wdata;
  logic [REG_CRC_W-1:0] r_wcrc;
  logic                 r_addr_ok;

  logic                 r_reg_wr_en;
  logic                 r_reg_rd_en;
  logic [REG_AW-1:0]    r_reg_addr;
  logic [REG_DW-1:0]    r_reg_wdata;
  logic                 r_crc_err;
  logic                 r_addr_err;
  logic                 r_wack;
  logic                 r_rack;
  logic [REG_DW-1:0]    r_rac_data;
  logic [REG_AW-1:0]    r_rac_addr;

  logic [15:0]          w_crc_in;
  logic [7:0]           w_crc;
  logic                 w_crc_ok;
  logic                 w_addr_ok;

  // The CRC message is the 16-bit word {1'b0, addr, wdata}.
  assign w_crc_in  = 16'({1'b0, r_addr, r_wdata});
  assign w_crc_ok  = (w_crc == r_wcrc);
  assign w_addr_ok = ({1'b0, r_addr} < REG_NUM_W);

  crc16to8_parallel u_crc (
    .i_data (w_crc_in),
    .o_crc  (w_crc)
  );

  // NOTE: sequential state uses non-blocking '<=' so all registers update
  // together from pre-edge values, independent of statement order.
  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      r_state     <= ST_IDLE;
      r_op        <= OP_WR;
      r_addr      <= '0;
      r_wdata     <= '0;
      r_wcrc      <= '0;
      r_addr_ok   <= 1'b0;
      r_reg_wr_en <= 1'b0;
      r_reg_rd_en <= 1'b0;
      r_reg_addr  <= '0;
      r_reg_wdata <= '0;
      r_crc_err   <= 1'b0;
      r_addr_err  <= 1'b0;
      r_wack      <= 1'b0;
      r_rack      <= 1'b0;
      r_rac_data  <= '0;
      r_rac_addr  <= '0;
    end else begin
      // Strobes, error flags and acks are single-cycle pulses.
      r_reg_wr_en <= 1'b0;
      r_reg_rd_en <= 1'b0;
      r_crc_err   <= 1'b0;
      r_addr_err  <= 1'b0;
      r_wack      <= 1'b0;
      r_rack      <= 1'b0;

      case (r_state)
        ST_IDLE: begin
          if (rac.i_rac_wr_req || rac.i_rac_rd_req) begin
            // A simultaneous read is dropped: write has priority.
            r_op    <= rac.i_rac_wr_req ? OP_WR : OP_RD;
            r_addr  <= rac.i_rac_addr;
            r_wdata <= rac.i_rac_wdata;
            r_wcrc  <= rac.i_rac_wcrc;
            r_state <= ST_CHK;
          end
        end

        ST_CHK: begin
          // Check results are registered straight into the EXE-cycle strobes
          // and error pulses, so those outputs come from flops only.
          r_addr_ok   <= w_addr_ok;
          r_reg_addr  <= r_addr;
          r_reg_wdata <= r_wdata;
          r_addr_err  <= !w_addr_ok;
          if (r_op == OP_WR) begin
            r_reg_wr_en <= w_crc_ok && w_addr_ok;
            r_crc_err   <= !w_crc_ok;
          end else begin
            r_reg_rd_en <= w_addr_ok;
          end
          r_state <= ST_EXE;
        end

        ST_EXE: begin
          if (r_op == OP_RD && r_addr_ok) begin
            r_state <= ST_RDW;
          end else begin
            // Writes (good or dropped) and out-of-range reads ack directly.
            if (r_op == OP_WR) begin
              r_wack <= 1'b1;
            end else begin
              r_rack     <= 1'b1;
              r_rac_data <= '0;
            end
            r_rac_addr <= r_addr;
            r_state    <= ST_ACK;
          end
        end

        ST_RDW: begin
          r_rac_data <= i_reg_rdata;
          r_rac_addr <= r_addr;
          r_rack     <= 1'b1;
          r_state    <= ST_ACK;
        end

        ST_ACK: begin
          r_state <= ST_IDLE;
        end

        default: begin
          r_state <= ST_IDLE;
        end
      endcase
    end
  end

`ifdef HV_RAC_ERR_CNT_EN
  logic [7:0] r_crc_err_cnt;

  // Counts each o_crc_err pulse; a clear in the same cycle wins.
  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      r_crc_err_cnt <= '0;
    end else if (i_err_cnt_clr) begin
      r_crc_err_cnt <= '0;
    end else if (r_crc_err && (r_crc_err_cnt != 8'hFF)) begin
      r_crc_err_cnt <= r_crc_err_cnt + 8'd1;
    end
  end

  assign o_crc_err_cnt = r_crc_err_cnt;
`else
  logic w_unused_err_cnt_clr;

  assign w_unused_err_cnt_clr = i_err_cnt_clr;
  assign o_crc_err_cnt        = '0;
`endif

  assign o_reg_wr_en    = r_reg_wr_en;
  assign o_reg_rd_en    = r_reg_rd_en;
  assign o_reg_addr     = r_reg_addr;
  assign o_reg_wdata    = r_reg_wdata;
  assign o_crc_err      = r_crc_err;
  assign o_addr_err     = r_addr_err;
  assign rac.o_rac_wack = r_wack;
  assign rac.o_rac_rack = r_rack;
  assign rac.o_rac_data = r_rac_data;
  assign rac.o_rac_addr = r_rac_addr;

endmodule

// File: tb/tb_hv_reg_acc_ctrl.sv
// -----------------------------------------------------------------------------
// tb_hv_reg_acc_ctrl
// Directed testbench for hv_reg_acc_ctrl. A small behavioural register file
// answers the controller's strobes. Expected CRC values are hand-computed
// CRC-8 (poly 0x07, init 0x00, MSB first) over {1'b0, addr, wdata}:
//   addr 0x05 data 0xA5 -> 0x33
//   addr 0x7F data 0x00 -> 0x61
//   addr 0x02 data 0x5A -> 0xAB
// Counter expectations follow HV_RAC_ERR_CNT_EN.
// -----------------------------------------------------------------------------
module tb_hv_reg_acc_ctrl;

`ifdef HV_RAC_ERR_CNT_EN
  localparam bit CNT_EN = 1'b1;
`else
  localparam bit CNT_EN = 1'b0;
`endif

  logic       clk = 1'b0;
  logic       rst_n;
  logic       o_reg_wr_en;
  logic       o_reg_rd_en;
  logic [6:0] o_reg_addr;
  logic [7:0] o_reg_wdata;
  logic [7:0] i_reg_rdata;
  logic       o_crc_err;
  logic       o_addr_err;
  logic       i_err_cnt_clr;
  logic [7:0] o_crc_err_cnt;

  int checks   = 0;
  int failures = 0;

  hv_rac_if #(.REG_AW(7), .REG_DW(8), .REG_CRC_W(8)) rac_bus ();

  hv_reg_acc_ctrl dut (
    .i_clk         (clk),
    .i_rst_n       (rst_n),
    .rac           (rac_bus.slave),
    .o_reg_wr_en   (o_reg_wr_en),
    .o_reg_rd_en   (o_reg_rd_en),
    .o_reg_addr    (o_reg_addr),
    .o_reg_wdata   (o_reg_wdata),
    .i_reg_rdata   (i_reg_rdata),
    .o_crc_err     (o_crc_err),
    .o_addr_err    (o_addr_err),
    .i_err_cnt_clr (i_err_cnt_clr),
    .o_crc_err_cnt (o_crc_err_cnt)
  );

  always #5 clk = ~clk;

  // Behavioural single-port register file: read data one cycle after rd_en.
  logic [7:0] mem [128];
  always @(posedge clk) begin
    if (o_reg_wr_en) mem[o_reg_addr] <= o_reg_wdata;
    if (o_reg_rd_en) i_reg_rdata <= mem[o_reg_addr];
  end

  // All DUT outputs packed together for reset-state comparisons.
  logic [43:0] all_outs;
  assign all_outs = {rac_bus.o_rac_wack, rac_bus.o_rac_rack, rac_bus.o_rac_data,
                     rac_bus.o_rac_addr, o_reg_wr_en, o_reg_rd_en, o_reg_addr,
                     o_reg_wdata, o_crc_err, o_addr_err, o_crc_err_cnt};

  // Per-transaction observations (cycle numbers relative to cycle 0).
  int wr_en_n, wr_en_first, wr_en_last;
  int rd_en_n, rd_en_first;
  int wack_n, wack_first, wack_last;
  int rack_n, rack_first;
  int crc_err_n, crc_err_first;
  int addr_err_n, addr_err_first;
  logic [6:0] cap_reg_addr, cap_rac_addr;
  logic [7:0] cap_wdata, cap_data;

  // Drives one request at the start of cycle 0 and observes ncyc cycles.
  // The request is dropped 'hold' cycles after the first ack is seen.
  // i_err_cnt_clr is asserted during cycle clr_cyc (-1: never).
  task automatic run_txn(input logic wr, input logic rd, input logic [6:0] addr,
                         input logic [7:0] wdata, input logic [7:0] crc,
                         input int hold, input int clr_cyc, input int ncyc);
    int drop_at;
    drop_at = -1;
    wr_en_n = 0; wr_en_first = -1; wr_en_last = -1;
    rd_en_n = 0; rd_en_first = -1;
    wack_n = 0; wack_first = -1; wack_last = -1;
    rack_n = 0; rack_first = -1;
    crc_err_n = 0; crc_err_first = -1;
    addr_err_n = 0; addr_err_first = -1;
    cap_reg_addr = '0; cap_rac_addr = '0; cap_wdata = '0; cap_data = '0;
    @(negedge clk);
    rac_bus.i_rac_wr_req = wr;
    rac_bus.i_rac_rd_req = rd;
    rac_bus.i_rac_addr   = addr;
    rac_bus.i_rac_wdata  = wdata;
    rac_bus.i_rac_wcrc   = crc;
    for (int c = 0; c < ncyc; c++) begin
      if (c > 0) begin
        @(posedge clk);
        @(negedge clk);
      end
      i_err_cnt_clr = (c == clr_cyc);
      if (o_reg_wr_en) begin
        wr_en_n++;
        if (wr_en_first < 0) wr_en_first = c;
        wr_en_last   = c;
        cap_reg_addr = o_reg_addr;
        cap_wdata    = o_reg_wdata;
      end
      if (o_reg_rd_en) begin
        rd_en_n++;
        if (rd_en_first < 0) rd_en_first = c;
      end
      if (rac_bus.o_rac_wack) begin
        wack_n++;
        if (wack_first < 0) wack_first = c;
        wack_last    = c;
        cap_rac_addr = rac_bus.o_rac_addr;
      end
      if (rac_bus.o_rac_rack) begin
        rack_n++;
        if (rack_first < 0) rack_first = c;
        cap_data     = rac_bus.o_rac_data;
        cap_rac_addr = rac_bus.o_rac_addr;
      end
      if (o_crc_err) begin
        crc_err_n++;
        if (crc_err_first < 0) crc_err_first = c;
      end
      if (o_addr_err) begin
        addr_err_n++;
        if (addr_err_first < 0) addr_err_first = c;
      end
      if ((rac_bus.o_rac_wack || rac_bus.o_rac_rack) && drop_at < 0) drop_at = c + hold;
      if (c == drop_at) begin
        rac_bus.i_rac_wr_req = 1'b0;
        rac_bus.i_rac_rd_req = 1'b0;
      end
    end
    rac_bus.i_rac_wr_req = 1'b0;
    rac_bus.i_rac_rd_req = 1'b0;
    i_err_cnt_clr        = 1'b0;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    rac_bus.i_rac_wr_req = 1'b1;
    repeat (3) @(posedge clk);
    @(negedge clk);
    checks++;
    if (all_outs !== 44'h0) begin
      failures++; $display("FAIL reset_outputs got=%h exp=0", all_outs);
    end
    rac_bus.i_rac_wr_req = 1'b0;
    rst_n = 1'b1;
    repeat (2) @(posedge clk);
    @(negedge clk);
    checks++;
    if (all_outs !== 44'h0) begin
      failures++; $display("FAIL idle_after_reset got=%h exp=0", all_outs);
    end
  endtask

  task automatic test_write_ok();
    run_txn(1'b1, 1'b0, 7'h05, 8'hA5, 8'h33, 0, -1, 8);
    checks++; if (wr_en_n !== 1) begin failures++; $display("FAIL wr_ok_wr_en_count got=%0d exp=1", wr_en_n); end
    checks++; if (wr_en_first !== 2) begin failures++; $display("FAIL wr_ok_wr_en_cycle got=%0d exp=2", wr_en_first); end
    checks++; if (cap_reg_addr !== 7'h05) begin failures++; $display("FAIL wr_ok_reg_addr got=%h exp=05", cap_reg_addr); end
    checks++; if (cap_wdata !== 8'hA5) begin failures++; $display("FAIL wr_ok_reg_wdata got=%h exp=a5", cap_wdata); end
    checks++; if (wack_first !== 3 || wack_n !== 1) begin failures++; $display("FAIL wr_ok_wack got cyc=%0d n=%0d exp cyc=3 n=1", wack_first, wack_n); end
    checks++; if (cap_rac_addr !== 7'h05) begin failures++; $display("FAIL wr_ok_rac_addr got=%h exp=05", cap_rac_addr); end
    checks++; if (crc_err_n + addr_err_n + rack_n + rd_en_n !== 0) begin failures++; $display("FAIL wr_ok_no_errors got crc=%0d addr=%0d rack=%0d rd=%0d exp all 0", crc_err_n, addr_err_n, rack_n, rd_en_n); end
  endtask

  task automatic test_readback();
    run_txn(1'b0, 1'b1, 7'h05, 8'h00, 8'h00, 0, -1, 8);
    checks++; if (rack_first !== 4 || cap_data !== 8'hA5) begin failures++; $display("FAIL readback got cyc=%0d data=%h exp cyc=4 data=a5", rack_first, cap_data); end
  endtask

  task automatic test_write_crc_err();
    run_txn(1'b1, 1'b0, 7'h05, 8'hA5, 8'h32, 0, -1, 8);
    checks++; if (wr_en_n !== 0) begin failures++; $display("FAIL crc_err_no_write got=%0d exp=0", wr_en_n); end
    checks++; if (crc_err_first !== 2 || crc_err_n !== 1) begin failures++; $display("FAIL crc_err_pulse got cyc=%0d n=%0d exp cyc=2 n=1", crc_err_first, crc_err_n); end
    checks++; if (addr_err_n !== 0) begin failures++; $display("FAIL crc_err_no_addr_err got=%0d exp=0", addr_err_n); end
    checks++; if (wack_first !== 3) begin failures++; $display("FAIL crc_err_wack got=%0d exp=3", wack_first); end
    checks++; if (o_crc_err_cnt !== (CNT_EN ? 8'h01 : 8'h00)) begin failures++; $display("FAIL crc_err_cnt got=%h exp=%h", o_crc_err_cnt, CNT_EN ? 8'h01 : 8'h00); end
  endtask

  task automatic test_read_ok();
    run_txn(1'b0, 1'b1, 7'h10, 8'h00, 8'h00, 0, -1, 8);
    checks++; if (rd_en_first !== 2 || rd_en_n !== 1) begin failures++; $display("FAIL rd_ok_rd_en got cyc=%0d n=%0d exp cyc=2 n=1", rd_en_first, rd_en_n); end
    checks++; if (rack_first !== 4 || rack_n !== 1) begin failures++; $display("FAIL rd_ok_rack got cyc=%0d n=%0d exp cyc=4 n=1", rack_first, rack_n); end
    checks++; if (cap_data !== 8'h3C) begin failures++; $display("FAIL rd_ok_data got=%h exp=3c", cap_data); end
    checks++; if (cap_rac_addr !== 7'h10) begin failures++; $display("FAIL rd_ok_addr got=%h exp=10", cap_rac_addr); end
    checks++; if (wack_n !== 0) begin failures++; $display("FAIL rd_ok_no_wack got=%0d exp=0", wack_n); end
  endtask

  task automatic test_addr_err();
    run_txn(1'b0, 1'b1, 7'h70, 8'h00, 8'h00, 0, -1, 8);
    checks++; if (rd_en_n !== 0) begin failures++; $display("FAIL rd_addr_err_no_rd_en got=%0d exp=0", rd_en_n); end
    checks++; if (addr_err_first !== 2) begin failures++; $display("FAIL rd_addr_err_pulse got=%0d exp=2", addr_err_first); end
    checks++; if (rack_first !== 3 || cap_data !== 8'h00 || cap_rac_addr !== 7'h70) begin failures++; $display("FAIL rd_addr_err_rack got cyc=%0d data=%h addr=%h exp cyc=3 data=00 addr=70", rack_first, cap_data, cap_rac_addr); end
    run_txn(1'b1, 1'b0, 7'h7F, 8'h00, 8'h61, 0, -1, 8);
    checks++; if (wr_en_n !== 0) begin failures++; $display("FAIL wr_addr_err_no_write got=%0d exp=0", wr_en_n); end
    checks++; if (addr_err_first !== 2 || crc_err_n !== 0) begin failures++; $display("FAIL wr_addr_err_pulse got cyc=%0d crc=%0d exp cyc=2 crc=0", addr_err_first, crc_err_n); end
    checks++; if (wack_first !== 3 || cap_rac_addr !== 7'h7F) begin failures++; $display("FAIL wr_addr_err_wack got cyc=%0d addr=%h exp cyc=3 addr=7f", wack_first, cap_rac_addr); end
  endtask

  task automatic test_both_req();
    run_txn(1'b1, 1'b1, 7'h02, 8'h5A, 8'hAB, 0, -1, 8);
    checks++; if (wr_en_first !== 2 || cap_reg_addr !== 7'h02 || cap_wdata !== 8'h5A) begin failures++; $display("FAIL both_req_write got cyc=%0d addr=%h data=%h exp cyc=2 addr=02 data=5a", wr_en_first, cap_reg_addr, cap_wdata); end
    checks++; if (wack_first !== 3) begin failures++; $display("FAIL both_req_wack got=%0d exp=3", wack_first); end
    checks++; if (rd_en_n !== 0 || rack_n !== 0) begin failures++; $display("FAIL both_req_no_read got rd=%0d rack=%0d exp 0 0", rd_en_n, rack_n); end
    run_txn(1'b0, 1'b1, 7'h02, 8'h00, 8'h00, 0, -1, 8);
    checks++; if (cap_data !== 8'h5A) begin failures++; $display("FAIL both_req_readback got=%h exp=5a", cap_data); end
  endtask

  task automatic test_back_to_back();
    // Request kept high through the IDLE cycle after the ack (cycle 4).
    run_txn(1'b1, 1'b0, 7'h05, 8'hA5, 8'h33, 2, -1, 11);
    checks++; if (wr_en_n !== 2 || wr_en_last !== 6) begin failures++; $display("FAIL b2b_wr_en got n=%0d last=%0d exp n=2 last=6", wr_en_n, wr_en_last); end
    checks++; if (wack_n !== 2 || wack_last !== 7) begin failures++; $display("FAIL b2b_wack got n=%0d last=%0d exp n=2 last=7", wack_n, wack_last); end
  endtask

  task automatic test_reset_mid();
    int seen;
    seen = 0;
    @(negedge clk);
    rac_bus.i_rac_wr_req = 1'b1;
    rac_bus.i_rac_addr   = 7'h05;
    rac_bus.i_rac_wdata  = 8'hA5;
    rac_bus.i_rac_wcrc   = 8'h33;
    @(posedge clk);
    @(negedge clk);
    // Cycle 1 (CHK): reset lands on the edge that would enter EXE.
    rst_n = 1'b0;
    rac_bus.i_rac_wr_req = 1'b0;
    @(posedge clk);
    @(negedge clk);
    checks++; if (all_outs !== 44'h0) begin failures++; $display("FAIL reset_mid_outputs got=%h exp=0", all_outs); end
    rst_n = 1'b1;
    for (int c = 0; c < 6; c++) begin
      @(posedge clk);
      @(negedge clk);
      if (o_reg_wr_en || rac_bus.o_rac_wack) seen++;
    end
    checks++; if (seen !== 0) begin failures++; $display("FAIL reset_mid_no_strobe_ack got=%0d exp=0", seen); end
  endtask

  task automatic test_err_cnt();
    for (int n = 0; n < 300; n++) run_txn(1'b1, 1'b0, 7'h05, 8'hA5, 8'h32, 0, -1, 5);
    checks++; if (o_crc_err_cnt !== (CNT_EN ? 8'hFF : 8'h00)) begin failures++; $display("FAIL err_cnt_saturate got=%h exp=%h", o_crc_err_cnt, CNT_EN ? 8'hFF : 8'h00); end
    // Clear asserted in the same cycle as the o_crc_err pulse.
    run_txn(1'b1, 1'b0, 7'h05, 8'hA5, 8'h32, 0, 2, 6);
    checks++; if (crc_err_first !== 2) begin failures++; $display("FAIL err_cnt_clr_pulse got=%0d exp=2", crc_err_first); end
    checks++; if (o_crc_err_cnt !== 8'h00) begin failures++; $display("FAIL err_cnt_clr_priority got=%h exp=00", o_crc_err_cnt); end
    run_txn(1'b1, 1'b0, 7'h05, 8'hA5, 8'h32, 0, -1, 6);
    checks++; if (o_crc_err_cnt !== (CNT_EN ? 8'h01 : 8'h00)) begin failures++; $display("FAIL err_cnt_after_clr got=%h exp=%h", o_crc_err_cnt, CNT_EN ? 8'h01 : 8'h00); end
  endtask

  initial begin
    #400000;
    $display("FAIL watchdog time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    for (int i = 0; i < 128; i++) mem[i] = 8'h00;
    mem[7'h10] = 8'h3C;
    i_reg_rdata          = 8'h00;
    rst_n                = 1'b0;
    i_err_cnt_clr        = 1'b0;
    rac_bus.i_rac_wr_req = 1'b0;
    rac_bus.i_rac_rd_req = 1'b0;
    rac_bus.i_rac_addr   = '0;
    rac_bus.i_rac_wdata  = '0;
    rac_bus.i_rac_wcrc   = '0;

    test_reset();
    test_write_ok();
    test_readback();
    test_write_crc_err();
    test_read_ok();
    test_addr_err();
    test_both_req();
    test_back_to_back();
    test_reset_mid();
    test_err_cnt();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
